switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/router_pkg.sv | 50 +++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/switch_allocator.sv | 159 +++++++++++++++
 tb/tb_switch_allocator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg -- shared definitions for the router switch allocator.
//   Port indices (N=0, E=1, W=2, S=3, L=4), flit-id encodings, the per-output
//   FSM state enum, the per-output context struct, and small round-robin
//   helper functions used by the allocator and its arbiters.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int IDX_W     = 3;
  localparam int FLIT_W    = 3;

  localparam logic [IDX_W-1:0] PORT_N = 3'd0;
  localparam logic [IDX_W-1:0] PORT_E = 3'd1;
  localparam logic [IDX_W-1:0] PORT_W = 3'd2;
  localparam logic [IDX_W-1:0] PORT_S = 3'd3;
  localparam logic [IDX_W-1:0] PORT_L = 3'd4;

  localparam logic [FLIT_W-1:0] FLIT_HEADER  = 3'b001;
  localparam logic [FLIT_W-1:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [FLIT_W-1:0] FLIT_TAIL    = 3'b100;

  // Bit positions inside a flit id; a single-flit packet carries both.
  localparam int HDR_BIT  = 0;
  localparam int TAIL_BIT = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sa_state_e;

  typedef struct packed {
    sa_state_e        st;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;
  } out_ctx_t;

  // Next port index, wrapping N..L.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] p);
    return (p >= IDX_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // One-hot to index; zero input maps to index 0.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (oh[i]) r = r | IDX_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin arbiter over NUM_PORTS requesters.
//   req : request vector, one bit per input
//   ptr : last-served index; search starts at ptr+1 and wraps
//   gnt : one-hot grant (all zero when no request)
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_next(idx);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator -- per-output packet-lock switch allocator for a 5-port
// wormhole router.
//   clk, rst        : clock; asynchronous active-high reset
//   in_valid[i]     : input FIFO i holds a flit
//   in_flit_id      : head flit id of input i at [3i+2:3i]
//   in_req          : routing request of input i at [5i+4:5i], bit o = output o
//   out_ready[o]    : downstream of output o can take a flit
//   in_pop[i]       : (comb) flit of input i transferred this cycle
//   out_valid[o]    : (comb) output o carries a valid flit
//   out_sel         : (reg) crossbar input index for output o at [3o+2:3o]
//   out_lock[o]     : (reg) output o held by a packet
//   timeout_err[o]  : (reg) one-cycle watchdog pulse, only with SA_TIMEOUT_EN
// Build option: define SA_TIMEOUT_EN to add a per-output idle-lock watchdog
// (parameter TIMEOUT_CYCLES) that drops a lock stuck without transfers.
module switch_allocator
  import router_pkg::*;
`ifdef SA_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0]    in_flit_id,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_req,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           in_pop,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*IDX_W-1:0]     out_sel,
  output logic [NUM_PORTS-1:0]           out_lock
`ifdef SA_TIMEOUT_EN
  ,
  output logic [NUM_PORTS-1:0]           timeout_err
`endif
);

  logic [NUM_PORTS-1:0]                hdr, tail, pay_bit;
  logic [NUM_PORTS-1:0]                locked, xfer, owned;
  logic [NUM_PORTS-1:0][IDX_W-1:0]     owner;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;
  // avail[o]: inputs still free for output o after locks held now and
  // grants made this cycle by lower-numbered outputs.
  logic [NUM_PORTS:0][NUM_PORTS-1:0]   avail;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    assign hdr[i]     = in_flit_id[FLIT_W*i + HDR_BIT];
    assign tail[i]    = in_flit_id[FLIT_W*i + TAIL_BIT];
    assign pay_bit[i] = in_flit_id[FLIT_W*i + 1];
  end

  // The payload marker is only meaningful downstream.
  logic unused_sigs;
  assign unused_sigs = ^{pay_bit, avail[NUM_PORTS]};

  always_comb begin
    owned = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      if (locked[o]) owned[owner[o]] = 1'b1;
  end

  always_comb begin
    in_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      if (xfer[o]) in_pop[owner[o]] = 1'b1;
  end

  assign avail[0] = ~owned;
  assign out_lock = locked;
  assign out_sel  = owner;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    out_ctx_t             ctx_q, ctx_d;
    logic [NUM_PORTS-1:0] req_col, arb_req;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_col
      assign req_col[i] = in_req[NUM_PORTS*i + o];
    end

    // Only a HEADER at the head of a free input may open a new lock.
    assign arb_req = (ctx_q.st == ST_IDLE) ? (in_valid & hdr & avail[o] & req_col) : '0;

    rr_arbiter u_arb (
      .req (arb_req),
      .ptr (ctx_q.ptr),
      .gnt (gnt[o])
    );

    assign avail[o+1]   = avail[o] & ~gnt[o];
    assign locked[o]    = (ctx_q.st == ST_LOCKED);
    assign owner[o]     = ctx_q.owner;
    assign out_valid[o] = locked[o] & in_valid[ctx_q.owner];
    assign xfer[o]      = locked[o] & in_valid[ctx_q.owner] & out_ready[o];

`ifdef SA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign timeout_err[o] = err_q;
`endif

    always_comb begin
      ctx_d = ctx_q;
`ifdef SA_TIMEOUT_EN
      cnt_d = cnt_q;
      err_d = 1'b0;
`endif
      if (!locked[o]) begin
        if (|gnt[o]) begin
          ctx_d.st    = ST_LOCKED;
          ctx_d.owner = onehot_idx(gnt[o]);
`ifdef SA_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end else if (xfer[o]) begin
`ifdef SA_TIMEOUT_EN
        cnt_d = '0;
`endif
        // A HEADER seen from the owner while locked is plain payload here.
        if (tail[ctx_q.owner]) begin
          ctx_d.st  = ST_IDLE;
          ctx_d.ptr = ctx_q.owner;
        end
      end
`ifdef SA_TIMEOUT_EN
      else begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ctx_d.st  = ST_IDLE;
          ctx_d.ptr = ctx_q.owner;
          cnt_d     = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
    end

    // Pointer resets to L so input N is searched first.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctx_q <= '{st: ST_IDLE, owner: '0, ptr: IDX_W'(NUM_PORTS - 1)};
`ifdef SA_TIMEOUT_EN
        cnt_q <= '0;
        err_q <= 1'b0;
`endif
      end else begin
        ctx_q <= ctx_d;
`ifdef SA_TIMEOUT_EN
        cnt_q <= cnt_d;
        err_q <= err_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
  import router_pkg::*;

  localparam int NP = 5;

  logic            clk, rst;
  logic [NP-1:0]   in_valid, out_ready, in_pop, out_valid, out_lock;
  logic [14:0]     in_flit_id, out_sel;
  logic [24:0]     in_req;
`ifdef SA_TIMEOUT_EN
  localparam int TMO = 8;
  logic [NP-1:0]   timeout_err;
`endif

  logic       tv [NP];
  logic [2:0] tf [NP];
  logic [4:0] tr [NP];

  int n_cmp = 0;
  int n_mis = 0;

`ifdef SA_TIMEOUT_EN
  switch_allocator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_flit_id (in_flit_id),
    .in_req     (in_req),
    .out_ready  (out_ready),
    .in_pop     (in_pop),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .out_lock   (out_lock),
    .timeout_err(timeout_err)
  );
`else
  switch_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_flit_id (in_flit_id),
    .in_req     (in_req),
    .out_ready  (out_ready),
    .in_pop     (in_pop),
    .out_valid  (out_valid),
    .out_sel    (out_sel),
    .out_lock   (out_lock)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    in_valid   = '0;
    in_flit_id = '0;
    in_req     = '0;
    for (int i = 0; i < NP; i++) begin
      in_valid[i]        = tv[i];
      in_flit_id[3*i+:3] = tf[i];
      in_req[5*i+:5]     = tr[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [2:0] f, input logic [4:0] r);
    tv[i] = v;
    tf[i] = f;
    tr[i] = r;
  endtask

  int m_lk [NP], m_own [NP], m_ptr [NP], m_cnt [NP];
  bit m_err [NP];

  function automatic void model_reset();
    for (int o = 0; o < NP; o++) begin
      m_lk[o] = 0; m_own[o] = 0; m_ptr[o] = 4; m_cnt[o] = 0; m_err[o] = 0;
    end
  endfunction

  initial begin : cmp
    int n_lk [NP], n_own [NP], n_ptr [NP], n_cnt [NP];
    bit n_err [NP];
    bit taken [NP];
    int w, ii;
    logic [NP-1:0] e_pop, e_val, e_lock, e_err;
    logic [14:0]   e_sel;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      e_pop = '0; e_val = '0; e_lock = '0; e_err = '0; e_sel = '0;
      for (int i = 0; i < NP; i++) taken[i] = 0;
      for (int o = 0; o < NP; o++) if (m_lk[o] != 0) taken[m_own[o]] = 1;
      for (int o = 0; o < NP; o++) begin
        n_lk[o] = m_lk[o]; n_own[o] = m_own[o]; n_ptr[o] = m_ptr[o];
        n_cnt[o] = m_cnt[o]; n_err[o] = 0;
        e_lock[o] = (m_lk[o] != 0);
        e_err[o]  = m_err[o];
        e_sel[3*o+:3] = 3'(m_own[o]);
        if (m_lk[o] != 0) begin
          w = m_own[o];
          if (tv[w]) e_val[o] = 1'b1;
          if (tv[w] && out_ready[o]) begin
            e_pop[w] = 1'b1;
            n_cnt[o] = 0;
            if (tf[w][2]) begin n_lk[o] = 0; n_ptr[o] = w; end
          end
`ifdef SA_TIMEOUT_EN
          else begin
            n_cnt[o] = m_cnt[o] + 1;
            if (n_cnt[o] >= TMO) begin
              n_lk[o] = 0; n_ptr[o] = w; n_err[o] = 1; n_cnt[o] = 0;
            end
          end
`endif
        end else begin
          for (int k = 1; k <= NP; k++) begin
            ii = (m_ptr[o] + k) % NP;
            if (n_lk[o] == 0 && tv[ii] && tf[ii][0] && tr[ii][o] && !taken[ii]) begin
              n_lk[o] = 1; n_own[o] = ii; n_cnt[o] = 0; taken[ii] = 1;
            end
          end
        end
      end
      chk("cyc_out_lock",  32'(out_lock),  32'(e_lock));
      chk("cyc_out_sel",   32'(out_sel),   32'(e_sel));
      chk("cyc_in_pop",    32'(in_pop),    32'(e_pop));
      chk("cyc_out_valid", 32'(out_valid), 32'(e_val));
`ifdef SA_TIMEOUT_EN
      chk("cyc_timeout_err", 32'(timeout_err), 32'(e_err));
`endif
      @(posedge clk);
      if (rst) model_reset();
      else begin
        for (int o = 0; o < NP; o++) begin
          m_lk[o] = n_lk[o]; m_own[o] = n_own[o]; m_ptr[o] = n_ptr[o];
          m_cnt[o] = n_cnt[o]; m_err[o] = n_err[o];
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [2:0] f3 [8];
  logic       r3 [8];
  int         pops;
  bit         held;

  initial begin : stim
    for (int i = 0; i < NP; i++) set_in(i, 1'b0, 3'b000, 5'b00000);
    out_ready = 5'h1f;
    rst = 1'b0;
    #1 rst = 1'b1;

    @(negedge clk);
    chk("rst_out_lock", 32'(out_lock), 0);
    chk("rst_out_sel",  32'(out_sel),  0);
    chk("rst_in_pop",   32'(in_pop),   0);
    @(posedge clk); #1 rst = 1'b0;

    step(); set_in(2, 1'b1, FLIT_HEADER, 5'b00010);
    @(negedge clk); chk("w2e_pre_lock", 32'(out_lock), 0);
    step(); @(negedge clk);
    chk("w2e_lock",  32'(out_lock),  32'h02);
    chk("w2e_sel",   32'(out_sel[5:3]), 2);
    chk("w2e_pop",   32'(in_pop),    32'h04);
    chk("w2e_valid", 32'(out_valid), 32'h02);
    step(); set_in(2, 1'b1, FLIT_PAYLOAD, 5'b00010);
    @(negedge clk); chk("w2e_pay_pop", 32'(in_pop), 32'h04);
    step(); set_in(2, 1'b1, FLIT_TAIL, 5'b00010);
    @(negedge clk); chk("w2e_tail_pop", 32'(in_pop), 32'h04);
    step(); set_in(2, 1'b0, 3'b000, 5'b00000);
    @(negedge clk); chk("w2e_release", 32'(out_lock), 0);

    step();
    set_in(0, 1'b1, 3'b101, 5'b10000);
    set_in(3, 1'b1, FLIT_HEADER, 5'b10000);
    step(); @(negedge clk);
    chk("ns2l_lock", 32'(out_lock), 32'h10);
    chk("ns2l_sel_n", 32'(out_sel[14:12]), 0);
    chk("ns2l_pop_n", 32'(in_pop), 32'h01);
    step(); set_in(0, 1'b0, 3'b000, 5'b00000);
    @(negedge clk); chk("ns2l_gap", 32'(out_lock), 0);
    step(); @(negedge clk);
    chk("ns2l_sel_s", 32'(out_sel[14:12]), 3);
    chk("ns2l_pop_s", 32'(in_pop), 32'h08);
    step(); set_in(3, 1'b1, FLIT_TAIL, 5'b10000);
    @(negedge clk); chk("ns2l_tail_s", 32'(in_pop), 32'h08);
    step(); set_in(3, 1'b0, 3'b000, 5'b00000);
    @(negedge clk); chk("ns2l_release", 32'(out_lock), 0);

    f3 = '{FLIT_HEADER, FLIT_HEADER, FLIT_PAYLOAD, FLIT_PAYLOAD,
           FLIT_PAYLOAD, FLIT_PAYLOAD, FLIT_PAYLOAD, FLIT_TAIL};
    r3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pops = 0; held = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      set_in(1, 1'b1, f3[c], 5'b00100);
      out_ready = r3[c] ? 5'h1f : 5'h1b;
      @(negedge clk);
      if (c > 0 && out_lock[2] !== 1'b1) held = 1'b0;
      if (in_pop[1] === 1'b1) pops++;
      step();
    end
    set_in(1, 1'b0, 3'b000, 5'b00000);
    out_ready = 5'h1f;
    chk("stall_pops", 32'(pops), 4);
    chk("stall_lock_held", 32'(held), 1);
    @(negedge clk); chk("stall_release", 32'(out_lock), 0);

    step(); set_in(4, 1'b1, FLIT_HEADER, 5'b00011);
    step(); @(negedge clk);
    chk("l2ne_lock", 32'(out_lock), 32'h01);
    chk("l2ne_sel",  32'(out_sel[2:0]), 4);
    step(); set_in(4, 1'b1, FLIT_TAIL, 5'b00011);
    @(negedge clk); chk("l2ne_tail_pop", 32'(in_pop), 32'h10);
    step(); set_in(4, 1'b0, 3'b000, 5'b00000);
    @(negedge clk); chk("l2ne_release", 32'(out_lock), 0);

    step(); set_in(0, 1'b1, FLIT_HEADER, 5'b01000);
    step(); @(negedge clk); chk("rstmid_lock", 32'(out_lock), 32'h08);
    step(); set_in(0, 1'b1, FLIT_PAYLOAD, 5'b01000);
    @(negedge clk); chk("rstmid_pay_pop", 32'(in_pop), 32'h01);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_lock_clr", 32'(out_lock), 0);
    chk("rstmid_pop_clr",  32'(in_pop),   0);
    @(posedge clk); #1 rst = 1'b0;
    set_in(0, 1'b0, 3'b000, 5'b00000);
    set_in(1, 1'b1, FLIT_HEADER, 5'b10000);
    set_in(4, 1'b1, FLIT_HEADER, 5'b10000);
    step(); @(negedge clk);
    chk("rstmid_relock", 32'(out_lock), 32'h10);
    chk("rstmid_sel",    32'(out_sel[14:12]), 1);
    chk("rstmid_pop",    32'(in_pop), 32'h02);
    step(); set_in(1, 1'b1, FLIT_TAIL, 5'b10000); set_in(4, 1'b0, 3'b000, 5'b00000);
    step(); set_in(1, 1'b0, 3'b000, 5'b00000);
    @(negedge clk); chk("rstmid_release", 32'(out_lock), 0);

`ifdef SA_TIMEOUT_EN
    step(); set_in(0, 1'b1, FLIT_HEADER, 5'b00010);
    step(); @(negedge clk); chk("tmo_lock", 32'(out_lock), 32'h02);
    step(); set_in(0, 1'b0, 3'b000, 5'b00000);
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      chk("tmo_held", 32'(out_lock[1]), 1);
      step();
    end
    @(negedge clk);
    chk("tmo_err",  32'(timeout_err), 32'h02);
    chk("tmo_idle", 32'(out_lock), 0);
    step(); @(negedge clk);
    chk("tmo_err_pulse", 32'(timeout_err), 0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
